dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between the pipeline MM stage and a debug/loader port.
//  The CPU has fixed priority and is never delayed by default.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter_starve_cnt.sv | 44 ++++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// State codes ARB_IDLE/ARB_RESP and the default address width live here,
// imported by dmem_arbiter and dmem_arbiter_starve_cnt.
package dmem_arbiter_pkg;

  // Debug-slot FSM: IDLE waits for a request, RESP holds the response.
  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_RESP = 1'b1
  } arb_state_t;

  localparam int ARB_AW_DEFAULT         = 12;
  localparam int ARB_WIDTH_DEFAULT      = 32;
  localparam int ARB_STARVE_MAX_DEFAULT = 8;

  // Byte address to word address: bits [1:0] select a byte and are dropped.
  localparam int ARB_ADDR_LSB = 2;

  // Counter width able to hold 0 .. max_count-1 (at least one bit).
  function automatic int arb_cnt_width(input int max_count);
    return (max_count > 2) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Starvation guard for the debug port of dmem_arbiter.
// Only compiled when DMEM_ARB_STARVE_GUARD_EN is defined; the default build
// has no starvation guard, so this file is empty there.
//
// Counts consecutive cycles in which a waiting debug request loses the
// memory slot to the CPU. When a loss happens while the count already sits at
// STARVE_MAX-1, stall is raised for exactly the following cycle so the debug
// request gets through. The count saturates and clears on any debug accept.
`ifdef DMEM_ARB_STARVE_GUARD_EN
module dmem_arbiter_starve_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic incr,   // debug request waiting in IDLE and lost to the CPU
  input  logic clr,    // debug request accepted
  output logic stall   // one-cycle CPU stall pulse
);

  localparam int CW = arb_cnt_width(STARVE_MAX);
  localparam logic [CW-1:0] CNT_TOP = CW'(STARVE_MAX - 1);

  logic [CW-1:0] starve_cnt;

  // Saturating loss counter and the registered one-cycle stall pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      stall      <= 1'b0;
    end else begin
      // incr is already low while stall is high, so the pulse is one cycle.
      stall <= incr && (starve_cnt == CNT_TOP);
      if (clr) begin
        starve_cnt <= '0;
      end else if (incr && (starve_cnt != CNT_TOP)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline MM
// stage (fixed priority) and a debug/loader port that uses idle slots.
//
// Optional build macro: DMEM_ARB_STARVE_GUARD_EN
//   defined   -> a starved debug request forces a one-cycle CPU stall
//   undefined -> cpu_stall is tied low; debug only gets cycles with cpu_en=0
//
// Debug handshake: a request transfers in a cycle where dbg_req_valid and
// dbg_req_ready are both 1; the requester holds valid/we/addr/wdata stable
// until then. A response transfers in a cycle where dbg_rsp_valid and
// dbg_rsp_ready are both 1; dbg_rsp_rdata is stable while valid is high.
// One request may be outstanding; a new one is accepted no earlier than the
// cycle after the response transfer.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH      = ARB_WIDTH_DEFAULT,
  parameter int AW         = ARB_AW_DEFAULT,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  // MM stage
  input  logic             cpu_en,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_stall,
  // debug / loader request
  input  logic             dbg_req_valid,
  output logic             dbg_req_ready,
  input  logic             dbg_we,
  input  logic [31:0]      dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  // debug / loader response
  output logic             dbg_rsp_valid,
  input  logic             dbg_rsp_ready,
  output logic [WIDTH-1:0] dbg_rsp_rdata,
  // data memory
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  arb_state_t    arb_state;
  logic          cpu_owns;
  logic          dbg_accept;
  logic [AW-1:0] cpu_word;
  logic [AW-1:0] dbg_word;

  // Word addresses; upper bits are dropped so addresses wrap modulo 2**AW.
  assign cpu_word = cpu_addr[ARB_ADDR_LSB +: AW];
  assign dbg_word = dbg_addr[ARB_ADDR_LSB +: AW];

  // Byte-select and out-of-range address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[ARB_ADDR_LSB-1:0], cpu_addr[31:ARB_ADDR_LSB+AW],
                              dbg_addr[ARB_ADDR_LSB-1:0], dbg_addr[31:ARB_ADDR_LSB+AW]};

  // The CPU wins every cycle it asks, unless the starvation guard stalls it.
  assign cpu_owns = cpu_en & ~cpu_stall;

  // A debug access happens in the cycle the request is accepted. Gating
  // with rst_n keeps the port quiet while reset is held.
  assign dbg_accept    = rst_n & (arb_state == ARB_IDLE) & dbg_req_valid & ~cpu_owns;
  assign dbg_req_ready = dbg_accept;

  // Load data goes straight back to the MM stage.
  assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic starve_incr;

  // A loss is a waiting debug request in IDLE beaten by a live CPU access.
  assign starve_incr = (arb_state == ARB_IDLE) & dbg_req_valid & cpu_en & ~cpu_stall;

  dmem_arbiter_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .incr  (starve_incr),
    .clr   (dbg_accept),
    .stall (cpu_stall)
  );
`else
  // Without the guard the CPU is never delayed.
  assign cpu_stall = 1'b0;

  logic unused_starve_max;
  assign unused_starve_max = (STARVE_MAX != 0);
`endif

  // Memory port mux: the owner drives address and data; only an active
  // owner may raise the write enable.
  always_comb begin
    mem_addr  = dbg_word;
    mem_wdata = dbg_wdata;
    mem_we    = 1'b0;
    if (cpu_owns) begin
      mem_addr  = cpu_word;
      mem_wdata = cpu_wdata;
      mem_we    = rst_n & cpu_we;
    end else begin
      mem_we    = dbg_accept & dbg_we;
    end
  end

  // Debug slot FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_state     <= ARB_IDLE;
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_rdata <= '0;
    end else begin
      case (arb_state)
        ARB_IDLE: begin
          if (dbg_accept) begin
            // Reads capture the memory word now; writes answer with zero.
            dbg_rsp_rdata <= dbg_we ? '0 : mem_rdata;
            dbg_rsp_valid <= 1'b1;
            arb_state     <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // Response data is held until the consumer takes it.
          if (dbg_rsp_ready) begin
            dbg_rsp_valid <= 1'b0;
            arb_state     <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (reference memory, outstanding-response
// queue, and in guard builds a count of consecutive lost debug cycles).
module tb_dmem_arbiter;

  localparam int WIDTH      = 32;
  localparam int AW         = 12;
  localparam int STARVE_MAX = 8;
  localparam int DEPTH      = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic             cpu_en, cpu_we, cpu_stall;
  logic [31:0]      cpu_addr;
  logic [WIDTH-1:0] cpu_wdata, cpu_rdata;
  logic             dbg_req_valid, dbg_req_ready, dbg_we;
  logic [31:0]      dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_rsp_valid, dbg_rsp_ready;
  logic [WIDTH-1:0] dbg_rsp_rdata;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic             mem_we;

  dmem_arbiter #(
    .WIDTH      (WIDTH),
    .AW         (AW),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_en        (cpu_en),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_ready (dbg_rsp_ready),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_we        (mem_we),
    .mem_rdata     (mem_rdata)
  );

  // ---------------- single-port memory (environment) ----------------
  logic [WIDTH-1:0] dmem [DEPTH];
  logic             fill_mem;

  function automatic logic [WIDTH-1:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  assign mem_rdata = dmem[mem_addr];

  always @(posedge clk) begin
    if (fill_mem) begin
      for (int i = 0; i < DEPTH; i++) dmem[i] <= init_word(i);
    end else if (mem_we) begin
      dmem[mem_addr] <= mem_wdata;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  int               n_checks = 0;
  int               n_errors = 0;
  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_busy;
  logic             m_accepted;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  int               m_lost;
`endif

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy     = 1'b0;
    m_accepted = 1'b0;
    exp_q.delete();
`ifdef DMEM_ARB_STARVE_GUARD_EN
    m_lost = 0;
`endif
  endtask

  // One clock cycle with the inputs currently driven: predict, check at the
  // falling edge, then advance the model across the rising edge.
  task automatic run_cycle();
    logic          exp_stall, cpu_act, exp_ready, exp_we, was_busy;
    logic [AW-1:0] ca, da;
    ca = cpu_addr[2 +: AW];
    da = dbg_addr[2 +: AW];
`ifdef DMEM_ARB_STARVE_GUARD_EN
    exp_stall = (m_lost == STARVE_MAX);
`else
    exp_stall = 1'b0;
`endif
    was_busy  = m_busy;
    cpu_act   = cpu_en && !exp_stall;
    exp_ready = dbg_req_valid && !m_busy && !cpu_act;
    exp_we    = cpu_act ? cpu_we : (exp_ready && dbg_we);

    @(negedge clk);
    check("cpu_stall", 32'(cpu_stall), 32'(exp_stall));
    check("req_ready", 32'(dbg_req_ready), 32'(exp_ready));
    check("rsp_valid", 32'(dbg_rsp_valid), 32'(m_busy));
    if (m_busy && exp_q.size() > 0) check("rsp_rdata", dbg_rsp_rdata, exp_q[0]);
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (cpu_act || exp_ready) check("mem_addr", 32'(mem_addr), 32'(cpu_act ? ca : da));
    if (exp_we) check("mem_wdata", mem_wdata, cpu_act ? cpu_wdata : dbg_wdata);
    if (cpu_act && !cpu_we) check("cpu_rdata", cpu_rdata, ref_mem[ca]);
    m_accepted = exp_ready;

    @(posedge clk);
    if (was_busy) begin
      if (dbg_rsp_ready) begin
        m_busy = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end else if (exp_ready) begin
      exp_q.push_back(dbg_we ? '0 : ref_mem[da]);
      m_busy = 1'b1;
      if (dbg_we) ref_mem[da] = dbg_wdata;
    end
    if (cpu_act && cpu_we) ref_mem[ca] = cpu_wdata;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    if (exp_ready) m_lost = 0;
    else if (!was_busy && dbg_req_valid && cpu_act) m_lost++;
`endif
    #1;
  endtask

  // ---------------- driver helpers ----------------
  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom();
    a[2 +: AW] = AW'($urandom_range(0, 15));
    return a;
  endfunction

  // Let any pending request and response finish with the CPU quiet.
  task automatic drain();
    cpu_en = 1'b0;
    dbg_rsp_ready = 1'b1;
    if (m_accepted) dbg_req_valid = 1'b0;
    for (int i = 0; i < 8 && (dbg_req_valid || m_busy); i++) begin
      run_cycle();
      if (m_accepted) dbg_req_valid = 1'b0;
    end
    check("drain_done", 32'(dbg_req_valid || m_busy), 32'(0));
    check("drain_rsp_valid", 32'(dbg_rsp_valid), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  logic [WIDTH-1:0] t4_data;
  int               stall_count, stall_at;

  initial begin
    rst_n = 1'b0; fill_mem = 1'b1;
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'hBAD0_BAD0;
    dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'hBAD1_BAD1;
    dbg_rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
    model_reset();

    // Reset state: quiet outputs and no write even with both ports asking.
    @(posedge clk); #1;
    check("rst_rsp_valid", 32'(dbg_rsp_valid), 32'(0));
    check("rst_rsp_rdata", dbg_rsp_rdata, 32'(0));
    check("rst_req_ready", 32'(dbg_req_ready), 32'(0));
    check("rst_cpu_stall", 32'(cpu_stall), 32'(0));
    check("rst_mem_we", 32'(mem_we), 32'(0));
    @(posedge clk); #1;
    fill_mem = 1'b0;
    cpu_en = 1'b0; cpu_we = 1'b0; dbg_req_valid = 1'b0;
    rst_n = 1'b1;

    // Idle debug write 0xDEADBEEF @0x40 -> word 0x10, response data 0.
    dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'hDEAD_BEEF;
    run_cycle();
    dbg_req_valid = 1'b0;
    check("t2_dmem", dmem[16], 32'hDEAD_BEEF);
    run_cycle();
    check("t2_rsp_valid", 32'(dbg_rsp_valid), 32'(1));
    check("t2_rsp_rdata", dbg_rsp_rdata, 32'(0));

    // CPU SW 0x1234 @0x8 (also consumes the pending response), then debug read.
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h1234;
    dbg_rsp_ready = 1'b1;
    run_cycle();
    cpu_en = 1'b0; cpu_we = 1'b0;
    dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h8; dbg_rsp_ready = 1'b0;
    run_cycle();
    dbg_req_valid = 1'b0;
    check("t3_rsp_valid", 32'(dbg_rsp_valid), 32'(1));
    check("t3_rsp_rdata", dbg_rsp_rdata, 32'h1234);

    // Backpressure: response held five cycles while a new request waits.
    t4_data = 32'h5EED_0044;
    dbg_req_valid = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h44; dbg_wdata = t4_data;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check("t4_rsp_valid", 32'(dbg_rsp_valid), 32'(1));
      check("t4_rsp_rdata", dbg_rsp_rdata, 32'h1234);
      check("t4_req_ready", 32'(dbg_req_ready), 32'(0));
    end
    dbg_rsp_ready = 1'b1;
    run_cycle();
    dbg_rsp_ready = 1'b0;
    run_cycle();
    check("t4_second_accept", 32'(m_accepted), 32'(1));
    dbg_req_valid = 1'b0;

    // Reset in the middle of RESP, with a CPU store pending on 0x44.
    rst_n = 1'b0;
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hBAD0_BAD0;
    dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h44;
    #1;
    check("t1_rsp_valid", 32'(dbg_rsp_valid), 32'(0));
    check("t1_rsp_rdata", dbg_rsp_rdata, 32'(0));
    check("t1_req_ready", 32'(dbg_req_ready), 32'(0));
    check("t1_cpu_stall", 32'(cpu_stall), 32'(0));
    @(negedge clk);
    check("t1_mem_we", 32'(mem_we), 32'(0));
    model_reset();
    @(posedge clk); #1;
    cpu_en = 1'b0; cpu_we = 1'b0;
    rst_n = 1'b1;
    dbg_rsp_ready = 1'b0;
    run_cycle();
    check("t1_idle_accept", 32'(m_accepted), 32'(1));
    dbg_req_valid = 1'b0;
    check("t1_read_back", dbg_rsp_rdata, t4_data);
    drain();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      cpu_en    = ($urandom_range(0, 1) == 1);
      cpu_we    = 1'($urandom_range(0, 1));
      cpu_addr  = rand_addr();
      cpu_wdata = $urandom();
      if (m_accepted || !dbg_req_valid) begin
        dbg_req_valid = ($urandom_range(0, 2) != 0);
        dbg_we        = 1'($urandom_range(0, 1));
        dbg_addr      = rand_addr();
        dbg_wdata     = $urandom();
      end
      dbg_rsp_ready = ($urandom_range(0, 1) == 1);
      run_cycle();
    end
    drain();

    // Contention: CPU busy every cycle while a debug read waits.
    dbg_req_valid = 1'b1; dbg_we = 1'b0; dbg_addr = rand_addr(); dbg_rsp_ready = 1'b1;
    stall_count = 0; stall_at = -1;
`ifdef DMEM_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 20; c++) begin
      cpu_en = 1'b1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rand_addr(); cpu_wdata = $urandom();
      if (cpu_stall) begin
        stall_count++;
        if (stall_at < 0) stall_at = c;
      end
      run_cycle();
      if (m_accepted) dbg_req_valid = 1'b0;
    end
    check("t5_stall_count", 32'(stall_count), 32'(1));
    check("t5_stall_cycle", 32'(stall_at), 32'(8));
    check("t5_dbg_done", 32'(dbg_req_valid), 32'(0));
`else
    for (int c = 0; c < 100; c++) begin
      cpu_en = 1'b1; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = rand_addr(); cpu_wdata = $urandom();
      run_cycle();
      if (dbg_req_ready) stall_count++;
      if (cpu_stall) stall_count++;
    end
    check("t6_never_ready_or_stall", 32'(stall_count), 32'(0));
`endif
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
